// File: rtl/coin_pkg.sv
// Shared types for the coin slot front-end.
package coin_pkg;

    typedef enum logic [2:0] {
        COIN_NONE = 3'd0,
        COIN_5C   = 3'd1,
        COIN_10C  = 3'd2,
        COIN_25C  = 3'd3,
        COIN_1D   = 3'd4,
        COIN_2D   = 3'd5
    } coin_t;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_ISSUE,
        DISP_BUSY
    } disp_state_t;

    localparam int TIMEOUT_CYCLES_DEF = 6000;

endpackage

// File: rtl/coin_fifo.sv
// Small coin buffer between the slot detector and the dispatcher.
module coin_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [2:0]               din,
    output logic [2:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign head  = empty ? 3'd0 : mem[rd_ptr];

    // A pop frees the slot, so a full buffer still takes a same-cycle push.
    always_comb begin
        do_pop    = pop && !empty && !flush;
        do_push   = push && !flush && (!full || do_pop);
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/coin_feed_ctrl.sv
// Slot front-end: buffers coins, feeds the casher, runs its timer and return request.
module coin_feed_ctrl
    import coin_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       slot_valid,
    input  logic [2:0] slot_type,
    input  logic       return_btn,
    input  logic       wait_ready,
    input  logic       timer_en,
    input  logic       reset_timer,
    input  logic       spit_coin,
    output logic       coin_insert,
    output logic [2:0] inserted_coin,
    output logic       return_coin,
    output logic       timer_finish,
    output logic       slot_full,
    output logic       drop_coin,
    output logic       chute_flush,
    output logic       timer_active
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    disp_state_t               state;
    disp_state_t               state_nxt;
    logic                      pop;
    logic                      empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [TW-1:0]             tcount;
    logic                      btn_q;

    coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (slot_valid && !spit_coin),
        .pop   (pop),
        .flush (spit_coin),
        .din   (slot_type),
        .head  (inserted_coin),
        .full  (slot_full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt   = state;
        coin_insert = 1'b0;
        pop         = 1'b0;
        unique case (state)
            DISP_IDLE: begin
                if (wait_ready && !empty && !return_coin && !timer_finish)
                    state_nxt = DISP_ISSUE;
            end
            DISP_ISSUE: begin
                coin_insert = !return_coin && !timer_finish;
                if (spit_coin) begin
                    state_nxt = DISP_BUSY;
                end else if (coin_insert && wait_ready) begin
                    pop       = 1'b1;
                    state_nxt = DISP_BUSY;
                end else begin
                    state_nxt = DISP_IDLE;
                end
            end
            DISP_BUSY: begin
                if (wait_ready)
                    state_nxt = DISP_IDLE;
            end
            default: state_nxt = DISP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DISP_IDLE;
            drop_coin   <= 1'b0;
            chute_flush <= 1'b0;
        end else begin
            state       <= state_nxt;
            drop_coin   <= slot_valid && (spit_coin || (slot_full && !pop));
            chute_flush <= spit_coin && (fifo_count != '0);
        end
    end

    // Countdown; timer_finish latches until the casher clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcount       <= '0;
            timer_active <= 1'b0;
            timer_finish <= 1'b0;
        end else if (reset_timer) begin
            tcount       <= '0;
            timer_active <= 1'b0;
            timer_finish <= 1'b0;
        end else if (timer_en) begin
            tcount       <= TW'(TIMEOUT_CYCLES);
            timer_active <= 1'b1;
        end else if (timer_active) begin
            tcount <= tcount - 1'b1;
            if (tcount == TW'(1)) begin
                timer_active <= 1'b0;
                timer_finish <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= 1'b0;
            return_coin <= 1'b0;
        end else begin
            btn_q <= return_btn;
            if (spit_coin)
                return_coin <= 1'b0;
            else if (return_btn && !btn_q)
                return_coin <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coin_feed_ctrl.sv
// Scoreboard bench for coin_feed_ctrl with a behavioural casher and reference model.
module tb_coin_feed_ctrl;

    localparam int DEPTH = 4;
    localparam int T     = 10;

    logic       clk;
    logic       rst_n;
    logic       slot_valid;
    logic [2:0] slot_type;
    logic       return_btn;
    logic       wait_ready;
    logic       timer_en;
    logic       reset_timer;
    logic       spit_coin;
    logic       coin_insert;
    logic [2:0] inserted_coin;
    logic       return_coin;
    logic       timer_finish;
    logic       slot_full;
    logic       drop_coin;
    logic       chute_flush;
    logic       timer_active;

    coin_feed_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .slot_valid    (slot_valid),
        .slot_type     (slot_type),
        .return_btn    (return_btn),
        .wait_ready    (wait_ready),
        .timer_en      (timer_en),
        .reset_timer   (reset_timer),
        .spit_coin     (spit_coin),
        .coin_insert   (coin_insert),
        .inserted_coin (inserted_coin),
        .return_coin   (return_coin),
        .timer_finish  (timer_finish),
        .slot_full     (slot_full),
        .drop_coin     (drop_coin),
        .chute_flush   (chute_flush),
        .timer_active  (timer_active)
    );

    typedef struct {
        logic drop;
        logic flush;
        logic full;
        logic ret;
        logic tfin;
        logic tact;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] disp_q[$];
    int         total;
    int         passed;
    logic       mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req)
            passed++;
        else
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Registered outputs, checked one step after each clock edge.
    always @(posedge clk) begin
        #1;
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("drop_coin", int'(drop_coin), int'(e.drop));
            chk("chute_flush", int'(chute_flush), int'(e.flush));
            chk("slot_full", int'(slot_full), int'(e.full));
            chk("return_coin", int'(return_coin), int'(e.ret));
            chk("timer_finish", int'(timer_finish), int'(e.tfin));
            chk("timer_active", int'(timer_active), int'(e.tact));
        end
    end

    // Dispatch handshakes: each accepted coin must be the oldest queued one.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (coin_insert && wait_ready && !spit_coin) begin
                if (disp_q.size() == 0) begin
                    chk("disp_unexpected", 1, 0);
                end else begin
                    logic [2:0] c;
                    c = disp_q.pop_front();
                    chk("disp_coin", int'(inserted_coin), int'(c));
                end
            end
            if (coin_insert)
                chk("insert_gate", int'({return_coin, timer_finish}), 0);
        end
    end

    initial begin
        int   occ;
        int   busy;
        int   n;
        int   en_edge;
        logic armed;
        logic tfin;
        logic ret;
        logic prev_btn;
        logic hs;
        logic seen;
        exp_t e;

        total = 0;
        passed = 0;
        mon_en = 1'b0;
        rst_n = 1'b0;
        slot_valid = 1'b0;
        slot_type = 3'd0;
        return_btn = 1'b0;
        wait_ready = 1'b0;
        timer_en = 1'b0;
        reset_timer = 1'b0;
        spit_coin = 1'b0;

        #1;
        chk("reset_outs", int'({coin_insert, inserted_coin, return_coin,
            timer_finish, slot_full, drop_coin, chute_flush, timer_active}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of activity.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            slot_valid = 1'b1;
            slot_type = 3'd4;
        end
        @(negedge clk);
        slot_valid = 1'b0;
        timer_en = 1'b1;
        @(negedge clk);
        timer_en = 1'b0;
        @(negedge clk);
        chk("pre_rst_head", int'(inserted_coin), 4);
        chk("pre_rst_tact", int'(timer_active), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", int'({coin_insert, inserted_coin, return_coin,
            timer_finish, slot_full, drop_coin, chute_flush, timer_active}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | coin_insert;
        end
        chk("post_rst_no_insert", int'(seen), 0);

        // Dispatch latency and single coin per wait visit.
        slot_valid = 1'b1;
        slot_type = 3'd3;
        @(negedge clk);
        slot_valid = 1'b0;
        chk("lat_early", int'(coin_insert), 0);
        @(negedge clk);
        chk("lat_insert", int'(coin_insert), 1);
        chk("lat_coin", int'(inserted_coin), 3);
        @(negedge clk);
        wait_ready = 1'b0;
        chk("after_pop_head", int'(inserted_coin), 0);
        chk("after_pop_insert", int'(coin_insert), 0);
        repeat (3) @(negedge clk);
        wait_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | coin_insert;
        end
        chk("no_second_insert", int'(seen), 0);

        // Fill, overflow, then flush.
        wait_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            slot_valid = 1'b1;
            slot_type = 3'(i + 1);
        end
        @(negedge clk);
        chk("full_after4", int'(slot_full), 1);
        chk("no_drop_yet", int'(drop_coin), 0);
        @(negedge clk);
        slot_valid = 1'b0;
        chk("drop_5th", int'(drop_coin), 1);
        chk("still_full", int'(slot_full), 1);
        chk("head_oldest", int'(inserted_coin), 1);
        @(negedge clk);
        chk("drop_one_pulse", int'(drop_coin), 0);
        spit_coin = 1'b1;
        @(negedge clk);
        spit_coin = 1'b0;
        chk("flush_pulse", int'(chute_flush), 1);
        chk("flush_not_full", int'(slot_full), 0);
        chk("flush_empty", int'(inserted_coin), 0);
        @(negedge clk);
        chk("flush_one_pulse", int'(chute_flush), 0);

        // Timeout exactly T edges after the timer_en edge.
        wait_ready = 1'b1;
        timer_en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            timer_en = 1'b0;
            if (k == 10) begin
                chk("tmr_not_yet", int'(timer_finish), 0);
                chk("tmr_running", int'(timer_active), 1);
            end
        end
        chk("tmr_finish", int'(timer_finish), 1);
        chk("tmr_stopped", int'(timer_active), 0);
        @(negedge clk);
        chk("tmr_holds", int'(timer_finish), 1);
        reset_timer = 1'b1;
        @(negedge clk);
        reset_timer = 1'b0;
        chk("tmr_cleared", int'(timer_finish), 0);

        // Randomised traffic against the reference model.
        occ = 0;
        busy = 0;
        n = 0;
        en_edge = 0;
        armed = 1'b0;
        tfin = 1'b0;
        ret = 1'b0;
        prev_btn = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (busy > 0) begin
                wait_ready = 1'b0;
                busy--;
            end else begin
                wait_ready = ($urandom_range(0, 7) != 0);
            end
            slot_valid = 1'($urandom_range(0, 1));
            slot_type = 3'($urandom_range(1, 5));
            spit_coin = !wait_ready && ($urandom_range(0, 24) == 0);
            timer_en = ($urandom_range(0, 39) == 0);
            reset_timer = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 14) == 0)
                return_btn = !return_btn;
            #1;
            hs = coin_insert && wait_ready && !spit_coin;
            if (hs)
                busy = 3;
            e.drop = slot_valid && (spit_coin || (occ == DEPTH && !hs));
            e.flush = spit_coin && (occ > 0);
            if (spit_coin) begin
                disp_q.delete();
                occ = 0;
            end else begin
                if (hs)
                    occ--;
                if (slot_valid && occ < DEPTH) begin
                    disp_q.push_back(slot_type);
                    occ++;
                end
            end
            e.full = (occ == DEPTH);
            if (spit_coin)
                ret = 1'b0;
            else if (return_btn && !prev_btn)
                ret = 1'b1;
            prev_btn = return_btn;
            n++;
            if (reset_timer) begin
                armed = 1'b0;
                tfin = 1'b0;
            end else if (timer_en) begin
                armed = 1'b1;
                en_edge = n;
            end else if (armed && (n - en_edge) >= T) begin
                armed = 1'b0;
                tfin = 1'b1;
            end
            e.ret = ret;
            e.tfin = tfin;
            e.tact = armed;
            exp_q.push_back(e);
        end
        @(negedge clk);
        slot_valid = 1'b0;
        spit_coin = 1'b0;
        timer_en = 1'b0;
        reset_timer = 1'b0;
        wait_ready = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
